gf2_ka_mul_seq: RTL

Parametrised, iterative Karatsuba multiplier for binary polynomials over GF(2), with carry-less products and XOR accumulation. It computes the full (2W−1)-bit product of two W-bit operands by reusing one H×H sub-multiplier across three cycles: low, high and middle. It replaces the fully unrolled three-multiplier arrangement where area matters more than throughput. It sits behind the field-arithmetic datapath with valid/ready handshakes on both sides and also offers a single-cycle squaring mode.

---
 rtl/gf2_pkg.sv | 39 +++
 rtl/gf2_clmul.sv | 24 ++
 rtl/gf2_ka_mul_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) polynomial arithmetic blocks.
//   gf2_state_e : sequencing states of the iterative Karatsuba multiplier
//   gf2_dbg_t   : debug view of the multiplier control state
//   gf2_half    : Karatsuba split point H for an operand width W
//   gf2_spread  : bit spread used for squaring (bit i moves to bit 2i)
package gf2_pkg;

  // Widest operand gf2_spread handles; wider users must raise this.
  localparam int GF2_MAX_W = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P_LO  = 3'd1,
    P_HI  = 3'd2,
    P_MID = 3'd3,
    DONE  = 3'd4
  } gf2_state_e;

  typedef struct packed {
    gf2_state_e state;
    logic       sq;
  } gf2_dbg_t;

  function automatic int gf2_half(input int w);
    return (w + 1) / 2;
  endfunction

  // Squaring over GF(2) has no cross terms: the square of a polynomial
  // is its coefficients interleaved with zeros.
  function automatic logic [2*GF2_MAX_W-2:0] gf2_spread(input logic [GF2_MAX_W-1:0] v);
    logic [2*GF2_MAX_W-2:0] r;
    r = '0;
    for (int i = 0; i < GF2_MAX_W; i++) begin
      r[2*i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gf2_clmul.sv
// Combinational H x H carry-less (schoolbook) multiplier over GF(2).
//   a_i, b_i : H-bit operand polynomials, bit i = coefficient of x^i
//   p_o      : (2H-1)-bit product polynomial
module gf2_clmul #(
  parameter int H = 36
) (
  input  logic [H-1:0]   a_i,
  input  logic [H-1:0]   b_i,
  output logic [2*H-2:0] p_o
);

  localparam int PW = 2 * H - 1;

  // XOR together a shifted copy of a_i for every set bit of b_i.
  always_comb begin
    p_o = '0;
    for (int i = 0; i < H; i++) begin
      if (b_i[i]) begin
        p_o = p_o ^ (PW'(a_i) << i);
      end
    end
  end

endmodule

// File: rtl/gf2_ka_mul_seq.sv
// Iterative Karatsuba multiplier for W-bit binary polynomials. One H x H
// carry-less sub-multiplier is reused for the low, high and middle
// partial products over three cycles; a squaring request bypasses the
// sub-multiplier and finishes in a single cycle.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : operands/mode valid          in_ready  : may accept (IDLE)
//   op_sq      : 1 = square a, 0 = a*b        a, b      : W-bit operands
//   out_valid  : y holds a result             out_ready : downstream takes y
//   y          : (2W-1)-bit product           dbg       : FSM state + mode
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its data stable until then. in_ready is
// high only in IDLE and out_valid only in DONE, so a result leaving and a
// new operation arriving never share an edge.
module gf2_ka_mul_seq
  import gf2_pkg::*;
#(
  parameter int W = 71,
  parameter int H = gf2_half(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           op_sq,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-2:0] y,
  output gf2_dbg_t       dbg
);

  localparam int PW = 2 * H - 1;  // sub-product width
  localparam int YW = 2 * W - 1;  // full product width
  localparam int AW = 4 * H - 1;  // combine width before truncation

  gf2_state_e      state_q, state_d;
  logic            in_ready_q, out_valid_q, sq_q;
  logic [W-1:0]    a_q, b_q;
  logic [PW-1:0]   lo_q, hi_q;
  logic [YW-1:0]   y_q;

  logic            accept;
  logic [H-1:0]    a_lo, a_hi, a_mid, b_lo, b_hi, b_mid;
  logic [H-1:0]    mul_a, mul_b;
  logic [PW-1:0]   prod, mid;
  logic [AW-1:0]   acc;
  logic [YW-1:0]   y_mul, y_sq;

  assign accept = in_valid && in_ready_q;

  // The high half is zero-extended, so for odd W its top bit is always 0.
  assign a_lo  = a_q[H-1:0];
  assign a_hi  = H'(a_q >> H);
  assign a_mid = a_lo ^ a_hi;
  assign b_lo  = b_q[H-1:0];
  assign b_hi  = H'(b_q >> H);
  assign b_mid = b_lo ^ b_hi;

  always_comb begin
    mul_a = a_lo;
    mul_b = b_lo;
    case (state_q)
      P_HI: begin
        mul_a = a_hi;
        mul_b = b_hi;
      end
      P_MID: begin
        mul_a = a_mid;
        mul_b = b_mid;
      end
      default: ;
    endcase
  end

  gf2_clmul #(.H(H)) u_clmul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  // In P_MID prod is (a_lo^a_hi)(b_lo^b_hi); removing lo and hi leaves
  // the cross term. hi << 2H stays within 2W-1 bits for odd W as well.
  assign mid   = prod ^ lo_q ^ hi_q;
  assign acc   = AW'(lo_q) ^ (AW'(mid) << H) ^ (AW'(hi_q) << (2 * H));
  assign y_mul = YW'(acc);
  assign y_sq  = YW'(gf2_spread(GF2_MAX_W'(a)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = op_sq ? DONE : P_LO;
      P_LO:    state_d = P_HI;
      P_HI:    state_d = P_MID;
      P_MID:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sq_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      y_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q  <= a;
            b_q  <= b;
            sq_q <= op_sq;
            if (op_sq) y_q <= y_sq;
          end
        end
        P_LO:    lo_q <= prod;
        P_HI:    hi_q <= prod;
        P_MID:   y_q  <= y_mul;
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign dbg.state = state_q;
  assign dbg.sq    = sq_q;

endmodule
